// File: rtl/ota_bitstream_decimator.sv
// rtl/ota_bitstream_decimator.sv - Ones-count decimator for the OTA bitstream with a valid/ready sample buffer
module ota_bitstream_decimator #(
  parameter int DEC_LOG2 = 8,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             bit_drv,
  output logic [OUT_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             busy
);

  // Accumulator holds 0..2^DEC_LOG2, so it needs one bit more than the window counter.
  localparam int AW = DEC_LOG2 + 1;
  // Common width used to compare the window result against the sample ceiling.
  localparam int CW = (OUT_W > AW) ? OUT_W : AW;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;

  logic                bit_m_q, bit_s_q;
  logic                drv_m_q, drv_s_q;
  logic                held_q, held_d;

  logic [AW-1:0]       acc_q, acc_d;
  logic [DEC_LOG2-1:0] win_q, win_d;

  logic [OUT_W-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  logic [AW-1:0]       result;
  logic [CW-1:0]       res_ext;
  logic [CW-1:0]       max_ext;
  logic [OUT_W-1:0]    sample_sat;
  logic                dump;
  logic                xfer;

  // Two-flop synchronizers for the asynchronous OTA bit and its drive-enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_m_q <= 1'b0;
      bit_s_q <= 1'b0;
      drv_m_q <= 1'b0;
      drv_s_q <= 1'b0;
    end else begin
      bit_m_q <= bit_in;
      bit_s_q <= bit_m_q;
      drv_m_q <= bit_drv;
      drv_s_q <= drv_m_q;
    end
  end

  // Window result including the current held bit, saturated to the sample width.
  always_comb begin
    result     = acc_q + AW'(held_q);
    res_ext    = CW'(result);
    max_ext    = CW'({OUT_W{1'b1}});
    sample_sat = (res_ext > max_ext) ? max_ext[OUT_W-1:0] : res_ext[OUT_W-1:0];
  end

  // Next-state logic: hold-last-driven bit, window FSM and accumulator.
  always_comb begin
    held_d  = drv_s_q ? bit_s_q : held_q;
    state_d = state_q;
    acc_d   = acc_q;
    win_d   = win_q;
    dump    = 1'b0;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        win_d = '0;
        if (en) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          // Abort drops the partial window; the output buffer is left alone.
          state_d = S_IDLE;
          acc_d   = '0;
          win_d   = '0;
        end else if (win_q == {DEC_LOG2{1'b1}}) begin
          // Last cycle of the window: emit and restart with no gap cycle.
          dump  = 1'b1;
          acc_d = '0;
          win_d = '0;
        end else begin
          acc_d = result;
          win_d = win_q + DEC_LOG2'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        win_d   = '0;
      end
    endcase
  end

  // Next-state logic for the single-entry output buffer and sticky overrun flag.
  always_comb begin
    xfer    = valid_q & sample_ready;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (dump) begin
      if (!valid_q || xfer) begin
        data_d  = sample_sat;
        valid_d = 1'b1;
      end else begin
        // Buffer still owned by the consumer: keep the old sample, flag the loss.
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State register for held bit, FSM, accumulator and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= 1'b0;
      state_q <= S_IDLE;
      acc_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      held_q  <= held_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q == S_RUN);

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// tb/tb_ota_bitstream_decimator.sv - Scoreboard bench for ota_bitstream_decimator
module tb_ota_bitstream_decimator;

  localparam int N  = 256;
  localparam int N4 = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       en4;
  logic       bit_in;
  logic       bit_drv;
  logic       sample_ready;
  logic       toggle;

  logic [7:0] sample_data;
  logic       sample_valid;
  logic       overrun;
  logic       busy;

  logic [7:0] sample_data4;
  logic       sample_valid4;
  logic       overrun4;
  logic       busy4;

  int         checks = 0;
  int         passed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];

  ota_bitstream_decimator #(.DEC_LOG2(8), .OUT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bit_in       (bit_in),
    .bit_drv      (bit_drv),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  ota_bitstream_decimator #(.DEC_LOG2(4), .OUT_W(8)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .en           (en4),
    .bit_in       (bit_in),
    .bit_drv      (bit_drv),
    .sample_data  (sample_data4),
    .sample_valid (sample_valid4),
    .sample_ready (1'b1),
    .overrun      (overrun4),
    .busy         (busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance n clock edges, driving inputs 1 ns after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (toggle) bit_in = ~bit_in;
    end
  endtask

  // Monitor for the 256-cycle decimator: compare each transferred sample.
  always @(negedge clk) begin
    if (!rst && sample_valid && sample_ready) begin
      chk("dec8 sample expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("dec8 sample", int'(sample_data), int'(exp_q.pop_front()));
    end
  end

  // Monitor for the 16-cycle decimator.
  always @(negedge clk) begin
    if (!rst && sample_valid4) begin
      chk("dec4 sample expected", int'(exp4_q.size() > 0), 1);
      if (exp4_q.size() > 0) chk("dec4 sample", int'(sample_data4), int'(exp4_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; en4 = 1'b0; bit_in = 1'b1; bit_drv = 1'b1;
    sample_ready = 1'b1; toggle = 1'b0;

    // Reset with en and bit_in high
    step(3);
    chk("reset sample_data", int'(sample_data), 0);
    chk("reset sample_valid", int'(sample_valid), 0);
    chk("reset overrun", int'(overrun), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1'b0;
    chk("busy before release edge", int'(busy), 0);
    step(1);
    chk("busy after release", int'(busy), 1);
    en = 1'b0;
    step(2);
    chk("busy after en low", int'(busy), 0);
    step(5);

    // Full ones: first sample at k+257, then every 256 cycles
    exp_q.push_back(8'd255);
    exp_q.push_back(8'd255);
    en = 1'b1;
    step(1);
    step(N - 1);
    chk("valid before first dump", int'(sample_valid), 0);
    step(1);
    chk("first dump valid", int'(sample_valid), 1);
    chk("first dump data", int'(sample_data), 255);
    step(N);
    chk("second dump valid", int'(sample_valid), 1);
    chk("second dump data", int'(sample_data), 255);
    en = 1'b0;
    step(3);

    // 50% stream on both decimators
    toggle = 1'b1;
    step(8);
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd128);
    for (int i = 0; i < 2 * N / N4; i++) exp4_q.push_back(8'd8);
    en = 1'b1; en4 = 1'b1;
    step(2 * N + 1);
    en = 1'b0; en4 = 1'b0;
    step(3);
    toggle = 1'b0;
    chk("dec4 all windows seen", exp4_q.size(), 0);

    // Undriven input keeps the held zero; then a driven-ones window
    bit_in = 1'b0; bit_drv = 1'b1;
    step(5);
    bit_drv = 1'b0; bit_in = 1'b1;
    step(5);
    exp_q.push_back(8'd0);
    en = 1'b1;
    step(N + 1);
    en = 1'b0;
    step(3);
    bit_drv = 1'b1;
    step(5);
    exp_q.push_back(8'd255);
    en = 1'b1;
    step(N + 1);
    en = 1'b0;
    step(3);

    // Backpressure across two dumps
    sample_ready = 1'b0;
    exp_q.push_back(8'd255);
    en = 1'b1;
    step(N + 1);
    chk("bp first valid", int'(sample_valid), 1);
    chk("bp first data", int'(sample_data), 255);
    chk("bp overrun before drop", int'(overrun), 0);
    bit_in = 1'b0;
    step(N);
    chk("bp data retained", int'(sample_data), 255);
    chk("bp valid retained", int'(sample_valid), 1);
    chk("bp overrun set", int'(overrun), 1);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    chk("bp valid after transfer", int'(sample_valid), 0);
    chk("bp data held after transfer", int'(sample_data), 255);
    exp_q.push_back(8'd0);
    step(N - 2);
    chk("bp valid before third dump", int'(sample_valid), 0);
    step(1);
    chk("bp third valid", int'(sample_valid), 1);
    chk("bp third data", int'(sample_data), 0);
    sample_ready = 1'b1;
    step(1);
    en = 1'b0;
    step(3);

    // Abort at window cycle 100, re-enter 5 cycles later
    bit_in = 1'b1;
    step(5);
    en = 1'b1;
    step(1 + 100);
    en = 1'b0; bit_in = 1'b0;
    step(5);
    chk("abort busy low", int'(busy), 0);
    chk("abort no sample", int'(sample_valid), 0);
    exp_q.push_back(8'd0);
    en = 1'b1;
    step(1);
    step(N - 1);
    chk("abort valid before dump", int'(sample_valid), 0);
    step(1);
    chk("abort dump valid", int'(sample_valid), 1);
    chk("abort dump data", int'(sample_data), 0);
    en = 1'b0;
    step(3);

    // Reset with a pending sample
    sample_ready = 1'b0; bit_in = 1'b1;
    step(5);
    en = 1'b1;
    step(N + 1);
    chk("pending valid", int'(sample_valid), 1);
    chk("pending overrun sticky", int'(overrun), 1);
    rst = 1'b1;
    step(1);
    chk("rst pending valid", int'(sample_valid), 0);
    chk("rst pending data", int'(sample_data), 0);
    chk("rst pending overrun", int'(overrun), 0);
    chk("rst pending busy", int'(busy), 0);
    rst = 1'b0; en = 1'b0;
    step(2);

    chk("dec8 leftover expected", exp_q.size(), 0);
    chk("dec4 leftover expected", exp4_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
